// File: rtl/text_cmd_decoder.sv
// Cursor-based UART command decoder for the text-mode screen buffer.
// Decodes control/argument bytes and drives the buffer write port.
module text_cmd_decoder #(
    parameter int N_COL         = 80,
    parameter int N_ROW         = 30,
    parameter int N_COL_WIDTH   = 7,
    parameter int N_ROW_WIDTH   = 5,
    parameter int DATA_WIDTH    = 8,
    parameter int N_CHARS_WIDTH = 7,
    parameter int ATTR_WIDTH    = 8,
    parameter logic [ATTR_WIDTH-1:0] DEFAULT_ATTR = 8'h0F,
    parameter int TIMEOUT_CYC   = 2500000,
    parameter int TO_WIDTH      = 22
) (
    input  logic                     clk_i,
    input  logic                     rstn_i,
    input  logic                     valid_i,
    input  logic [DATA_WIDTH-1:0]    data_i,
    output logic                     wr_en_o,
    output logic [N_COL_WIDTH-1:0]   col_w_o,
    output logic [N_ROW_WIDTH-1:0]   row_w_o,
    output logic [N_CHARS_WIDTH-1:0] char_o,
    output logic [ATTR_WIDTH-1:0]    attr_o,
    output logic [N_COL_WIDTH-1:0]   cursor_col_o,
    output logic [N_ROW_WIDTH-1:0]   cursor_row_o,
    output logic                     busy_o,
    output logic                     overrun_o
);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_ARG_COL  = 3'd1;
    localparam logic [2:0] S_ARG_ROW  = 3'd2;
    localparam logic [2:0] S_ARG_ATTR = 3'd3;
    localparam logic [2:0] S_CLEAR    = 3'd4;

    localparam logic [N_COL_WIDTH-1:0] COL_LAST = N_COL_WIDTH'(N_COL - 1);
    localparam logic [N_ROW_WIDTH-1:0] ROW_LAST = N_ROW_WIDTH'(N_ROW - 1);
    localparam logic [DATA_WIDTH-1:0]  COL_MAX_B = DATA_WIDTH'(N_COL - 1);
    localparam logic [DATA_WIDTH-1:0]  ROW_MAX_B = DATA_WIDTH'(N_ROW - 1);
    localparam logic [TO_WIDTH-1:0]    TO_LAST  = TO_WIDTH'(TIMEOUT_CYC - 1);

    localparam logic [DATA_WIDTH-1:0] B_SETPOS = DATA_WIDTH'('h01);
    localparam logic [DATA_WIDTH-1:0] B_ATTR   = DATA_WIDTH'('h02);
    localparam logic [DATA_WIDTH-1:0] B_CLEAR  = DATA_WIDTH'('h03);
    localparam logic [DATA_WIDTH-1:0] B_BS     = DATA_WIDTH'('h08);
    localparam logic [DATA_WIDTH-1:0] B_LF     = DATA_WIDTH'('h0A);
    localparam logic [DATA_WIDTH-1:0] B_CR     = DATA_WIDTH'('h0D);
    localparam logic [DATA_WIDTH-1:0] B_PR_LO  = DATA_WIDTH'('h20);
    localparam logic [DATA_WIDTH-1:0] B_PR_HI  = DATA_WIDTH'('h7E);

    localparam logic [N_CHARS_WIDTH-1:0] CHAR_SP = N_CHARS_WIDTH'('h20);

    function automatic logic [N_COL_WIDTH-1:0] col_inc(
        input logic [N_COL_WIDTH-1:0] c
    );
        return (c == COL_LAST) ? '0 : c + N_COL_WIDTH'(1);
    endfunction

    function automatic logic [N_ROW_WIDTH-1:0] row_inc(
        input logic [N_ROW_WIDTH-1:0] r
    );
        return (r == ROW_LAST) ? '0 : r + N_ROW_WIDTH'(1);
    endfunction

    logic [2:0]               state_q, state_d;
    logic                     valid_q;
    logic [TO_WIDTH-1:0]      to_q, to_d;
    logic [N_COL_WIDTH-1:0]   cur_col_q, cur_col_d;
    logic [N_ROW_WIDTH-1:0]   cur_row_q, cur_row_d;
    logic [N_COL_WIDTH-1:0]   arg_col_q, arg_col_d;
    logic [ATTR_WIDTH-1:0]    attr_q, attr_d;
    logic                     wr_en_q, wr_en_d;
    logic [N_COL_WIDTH-1:0]   col_w_q, col_w_d;
    logic [N_ROW_WIDTH-1:0]   row_w_q, row_w_d;
    logic [N_CHARS_WIDTH-1:0] char_q, char_d;
    logic                     busy_q, busy_d;
    logic                     overrun_q, overrun_d;
    logic [N_COL_WIDTH-1:0]   clr_col_q, clr_col_d;
    logic [N_ROW_WIDTH-1:0]   clr_row_q, clr_row_d;
    logic                     clr_done_q, clr_done_d;

    logic                     accept;
    logic                     arg_st;
    logic [N_COL_WIDTH-1:0]   col_clamp;
    logic [N_ROW_WIDTH-1:0]   row_clamp;

    assign accept = valid_i & ~valid_q;
    assign arg_st = (state_q == S_ARG_COL) || (state_q == S_ARG_ROW) ||
                    (state_q == S_ARG_ATTR);

    // Clamp raw argument bytes into the visible grid
    always_comb begin
        col_clamp = (data_i > COL_MAX_B) ? COL_LAST : data_i[N_COL_WIDTH-1:0];
        row_clamp = (data_i > ROW_MAX_B) ? ROW_LAST : data_i[N_ROW_WIDTH-1:0];
    end

    // Command decode, argument timeout and clear sequencing
    always_comb begin
        state_d    = state_q;
        to_d       = '0;
        cur_col_d  = cur_col_q;
        cur_row_d  = cur_row_q;
        arg_col_d  = arg_col_q;
        attr_d     = attr_q;
        wr_en_d    = 1'b0;
        col_w_d    = col_w_q;
        row_w_d    = row_w_q;
        char_d     = char_q;
        busy_d     = busy_q;
        overrun_d  = 1'b0;
        clr_col_d  = clr_col_q;
        clr_row_d  = clr_row_q;
        clr_done_d = clr_done_q;

        // A stalled partial command is abandoned; accepts win over expiry
        if (arg_st && !accept) begin
            if (to_q == TO_LAST) begin
                state_d = S_IDLE;
            end else begin
                to_d = to_q + TO_WIDTH'(1);
            end
        end

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (data_i == B_SETPOS) begin
                        state_d = S_ARG_COL;
                    end else if (data_i == B_ATTR) begin
                        state_d = S_ARG_ATTR;
                    end else if (data_i == B_CLEAR) begin
                        // First cell goes out with the accept itself
                        state_d    = S_CLEAR;
                        busy_d     = 1'b1;
                        wr_en_d    = 1'b1;
                        col_w_d    = '0;
                        row_w_d    = '0;
                        char_d     = CHAR_SP;
                        clr_col_d  = col_inc('0);
                        clr_row_d  = (COL_LAST == '0) ? row_inc('0) : '0;
                        clr_done_d = (COL_LAST == '0) && (ROW_LAST == '0);
                    end else if (data_i == B_LF) begin
                        cur_col_d = '0;
                        cur_row_d = row_inc(cur_row_q);
                    end else if (data_i == B_CR) begin
                        cur_col_d = '0;
                    end else if (data_i == B_BS) begin
                        if (cur_col_q != '0) begin
                            cur_col_d = cur_col_q - N_COL_WIDTH'(1);
                        end
                    end else if (data_i >= B_PR_LO && data_i <= B_PR_HI) begin
                        wr_en_d   = 1'b1;
                        col_w_d   = cur_col_q;
                        row_w_d   = cur_row_q;
                        char_d    = data_i[N_CHARS_WIDTH-1:0];
                        cur_col_d = col_inc(cur_col_q);
                        if (cur_col_q == COL_LAST) begin
                            cur_row_d = row_inc(cur_row_q);
                        end
                    end
                end
            end
            S_ARG_COL: begin
                if (accept) begin
                    arg_col_d = col_clamp;
                    state_d   = S_ARG_ROW;
                end
            end
            S_ARG_ROW: begin
                if (accept) begin
                    cur_col_d = arg_col_q;
                    cur_row_d = row_clamp;
                    state_d   = S_IDLE;
                end
            end
            S_ARG_ATTR: begin
                if (accept) begin
                    attr_d  = data_i[ATTR_WIDTH-1:0];
                    state_d = S_IDLE;
                end
            end
            S_CLEAR: begin
                if (accept) begin
                    overrun_d = 1'b1;
                end
                if (clr_done_q) begin
                    state_d   = S_IDLE;
                    busy_d    = 1'b0;
                    cur_col_d = '0;
                    cur_row_d = '0;
                end else begin
                    wr_en_d    = 1'b1;
                    col_w_d    = clr_col_q;
                    row_w_d    = clr_row_q;
                    char_d     = CHAR_SP;
                    clr_col_d  = col_inc(clr_col_q);
                    if (clr_col_q == COL_LAST) begin
                        clr_row_d = row_inc(clr_row_q);
                    end
                    clr_done_d = (clr_col_q == COL_LAST) &&
                                 (clr_row_q == ROW_LAST);
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State registers; valid history resets high to ignore a held level
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            state_q    <= S_IDLE;
            valid_q    <= 1'b1;
            to_q       <= '0;
            cur_col_q  <= '0;
            cur_row_q  <= '0;
            arg_col_q  <= '0;
            attr_q     <= DEFAULT_ATTR;
            wr_en_q    <= 1'b0;
            col_w_q    <= '0;
            row_w_q    <= '0;
            char_q     <= '0;
            busy_q     <= 1'b0;
            overrun_q  <= 1'b0;
            clr_col_q  <= '0;
            clr_row_q  <= '0;
            clr_done_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            valid_q    <= valid_i;
            to_q       <= to_d;
            cur_col_q  <= cur_col_d;
            cur_row_q  <= cur_row_d;
            arg_col_q  <= arg_col_d;
            attr_q     <= attr_d;
            wr_en_q    <= wr_en_d;
            col_w_q    <= col_w_d;
            row_w_q    <= row_w_d;
            char_q     <= char_d;
            busy_q     <= busy_d;
            overrun_q  <= overrun_d;
            clr_col_q  <= clr_col_d;
            clr_row_q  <= clr_row_d;
            clr_done_q <= clr_done_d;
        end
    end

    assign wr_en_o      = wr_en_q;
    assign col_w_o      = col_w_q;
    assign row_w_o      = row_w_q;
    assign char_o       = char_q;
    assign attr_o       = attr_q;
    assign cursor_col_o = cur_col_q;
    assign cursor_row_o = cur_row_q;
    assign busy_o       = busy_q;
    assign overrun_o    = overrun_q;

endmodule

// File: tb/tb_text_cmd_decoder.sv
// Bench for text_cmd_decoder: directed protocol steps plus random bytes
// checked against a cursor/attribute model of the command protocol.
module tb_text_cmd_decoder;

    localparam int N_COL  = 80;
    localparam int N_ROW  = 30;
    localparam int NCELL  = N_COL * N_ROW;
    localparam int TO_CYC = 40;

    logic       clk = 1'b0;
    logic       rstn_i;
    logic       valid_i;
    logic [7:0] data_i;
    logic       wr_en_o;
    logic [6:0] col_w_o;
    logic [4:0] row_w_o;
    logic [6:0] char_o;
    logic [7:0] attr_o;
    logic [6:0] cursor_col_o;
    logic [4:0] cursor_row_o;
    logic       busy_o;
    logic       overrun_o;

    always #5 clk = ~clk;

    text_cmd_decoder #(
        .TIMEOUT_CYC(TO_CYC),
        .TO_WIDTH   (6)
    ) dut (
        .clk_i       (clk),
        .rstn_i      (rstn_i),
        .valid_i     (valid_i),
        .data_i      (data_i),
        .wr_en_o     (wr_en_o),
        .col_w_o     (col_w_o),
        .row_w_o     (row_w_o),
        .char_o      (char_o),
        .attr_o      (attr_o),
        .cursor_col_o(cursor_col_o),
        .cursor_row_o(cursor_row_o),
        .busy_o      (busy_o),
        .overrun_o   (overrun_o)
    );

    int n_checks = 0;
    int n_errors = 0;

    // protocol model: cursor, attribute, which argument is awaited
    int m_col, m_row, m_attr, m_wait, m_pcol;
    int e_wr, e_col, e_row, e_chr, e_attr;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_col = 0; m_row = 0; m_attr = 'h0F; m_wait = 0; m_pcol = 0;
    endtask

    // m_wait: 0 none, 1 column arg, 2 row arg, 3 attribute arg
    task automatic model_step(input int b);
        int idx;
        e_wr = 0;
        if (m_wait == 1) begin
            m_pcol = (b > N_COL - 1) ? N_COL - 1 : b;
            m_wait = 2;
        end else if (m_wait == 2) begin
            m_col  = m_pcol;
            m_row  = (b > N_ROW - 1) ? N_ROW - 1 : b;
            m_wait = 0;
        end else if (m_wait == 3) begin
            m_attr = b;
            m_wait = 0;
        end else if (b == 1) begin
            m_wait = 1;
        end else if (b == 2) begin
            m_wait = 3;
        end else if (b == 'h0A) begin
            m_col = 0;
            m_row = (m_row + 1) % N_ROW;
        end else if (b == 'h0D) begin
            m_col = 0;
        end else if (b == 'h08) begin
            if (m_col > 0) m_col = m_col - 1;
        end else if (b >= 'h20 && b <= 'h7E) begin
            e_wr = 1; e_col = m_col; e_row = m_row;
            e_chr = b & 'h7F; e_attr = m_attr;
            idx = (m_row * N_COL + m_col + 1) % NCELL;
            m_col = idx % N_COL;
            m_row = idx / N_COL;
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        model_step(int'(b));
        @(negedge clk);
        data_i = b; valid_i = 1'b1;
        @(posedge clk); #1;
        check("wr_en", wr_en_o, e_wr);
        if (e_wr != 0) begin
            check("wr_col", col_w_o, e_col);
            check("wr_row", row_w_o, e_row);
            check("wr_char", char_o, e_chr);
            check("wr_attr", attr_o, e_attr);
        end
        check("cur_col", cursor_col_o, m_col);
        check("cur_row", cursor_row_o, m_row);
        check("attr", attr_o, m_attr);
        check("no_overrun", overrun_o, 0);
        check("not_busy", busy_o, 0);
        valid_i = 1'b0;
        @(posedge clk); #1;
        check("wr_single", wr_en_o, 0);
    endtask

    task automatic check_reset(input string t);
        check({t, "_wr"}, wr_en_o, 0);
        check({t, "_colw"}, col_w_o, 0);
        check({t, "_roww"}, row_w_o, 0);
        check({t, "_char"}, char_o, 0);
        check({t, "_attr"}, attr_o, 'h0F);
        check({t, "_ccol"}, cursor_col_o, 0);
        check({t, "_crow"}, cursor_row_o, 0);
        check({t, "_busy"}, busy_o, 0);
        check({t, "_ovr"}, overrun_o, 0);
    endtask

    task automatic do_clear(input int ovr_at, input int rst_at);
        int bad;
        bit aborted;
        bad = 0;
        aborted = 0;
        @(negedge clk);
        data_i = 8'h03; valid_i = 1'b1;
        @(posedge clk); #1;
        valid_i = 1'b0;
        check("clr_busy_rise", busy_o, 1);
        for (int i = 0; i < NCELL; i++) begin
            if (wr_en_o !== 1'b1 || busy_o !== 1'b1 ||
                int'(col_w_o) != i % N_COL ||
                int'(row_w_o) != i / N_COL ||
                int'(char_o) != 'h20 || int'(attr_o) != m_attr)
                bad++;
            if (ovr_at >= 0 && i == ovr_at) begin
                data_i = 8'h4B; valid_i = 1'b1;
            end
            if (ovr_at >= 0 && i == ovr_at + 1) begin
                check("overrun_pulse", overrun_o, 1);
                valid_i = 1'b0;
            end
            if (ovr_at >= 0 && i == ovr_at + 2)
                check("overrun_single", overrun_o, 0);
            if (i == rst_at) begin
                rstn_i = 1'b0; valid_i = 1'b1; data_i = 8'h4D;
                @(posedge clk); #1;
                check_reset("rst_midclr");
                aborted = 1;
                break;
            end
            @(posedge clk); #1;
        end
        check("clr_cells", bad, 0);
        if (!aborted) begin
            check("clr_busy_fall", busy_o, 0);
            check("clr_wr_end", wr_en_o, 0);
            check("clr_ccol", cursor_col_o, 0);
            check("clr_crow", cursor_row_o, 0);
            m_col = 0; m_row = 0;
        end
    endtask

    initial begin
        int r;
        logic [7:0] b;
        rstn_i = 1'b0; valid_i = 1'b0; data_i = 8'h00;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_reset("reset");
        rstn_i = 1'b1;
        @(posedge clk); #1;

        // two printable bytes
        send_byte("A");
        send_byte("B");

        // placement at last cell, wrap, clamp
        send_byte(8'h01); send_byte(8'd79); send_byte(8'd29);
        send_byte("Z");
        send_byte(8'h01); send_byte(8'd200); send_byte(8'd200);

        // attribute then control characters
        send_byte(8'h01); send_byte(8'd0); send_byte(8'd0);
        send_byte(8'h02); send_byte(8'h1E);
        send_byte("x");
        send_byte(8'h0D);
        send_byte(8'h08);
        send_byte(8'h0A);

        // clear with a dropped byte mid-sequence
        do_clear(500, -1);
        send_byte("c");

        // gaps under the timeout keep the command alive
        send_byte(8'h01);
        repeat (15) @(posedge clk);
        send_byte(8'd10);
        repeat (15) @(posedge clk);
        send_byte(8'd3);

        // stalled command is discarded
        send_byte(8'h01);
        send_byte(8'd5);
        repeat (TO_CYC + 5) @(posedge clk);
        m_wait = 0;
        send_byte("Q");

        // random byte stream
        for (int k = 0; k < 400; k++) begin
            r = $urandom_range(0, 99);
            if (r < 50) b = 8'($urandom_range(32, 126));
            else if (r < 56) b = 8'h0A;
            else if (r < 62) b = 8'h0D;
            else if (r < 68) b = 8'h08;
            else if (r < 78) b = 8'h01;
            else if (r < 84) b = 8'h02;
            else b = 8'($urandom_range(0, 255));
            if (b == 8'h03) b = 8'h04;
            send_byte(b);
            repeat ($urandom_range(0, 3)) @(posedge clk);
        end

        // reset during clear, valid held high through release
        do_clear(-1, 100);
        @(posedge clk); #1;
        rstn_i = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #1;
            check("noacc_wr", wr_en_o, 0);
            check("noacc_busy", busy_o, 0);
        end
        check("noacc_ccol", cursor_col_o, 0);
        valid_i = 1'b0;
        @(posedge clk); #1;
        model_reset();
        send_byte("M");

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule
